// File: rtl/operand_fetch_if.sv
// operand_fetch_if: issue, operand, writeback and register-file signals of operand_fetch
interface operand_fetch_if;
  logic       issueValid;
  logic       issueReady;
  logic [2:0] issueSrcA;
  logic [2:0] issueSrcB;
  logic [2:0] issueDest;
  logic       issueWritesDest;
  logic       opValid;
  logic       opReady;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [2:0] opDest;
  logic       wbValid;
  logic [2:0] wbDest;
  logic [7:0] wbData;
  logic [2:0] rfRegisterA;
  logic [2:0] rfRegisterB;
  logic [7:0] rfRegA;
  logic [7:0] rfRegB;
  logic       rfEnableWrite;
  logic [2:0] rfRegisterWrite;
  logic [7:0] rfDataIn;
  modport master (
    output issueValid, issueSrcA, issueSrcB, issueDest, issueWritesDest, opReady,
           wbValid, wbDest, wbData, rfRegA, rfRegB,
    input  issueReady, opValid, opA, opB, opDest,
           rfRegisterA, rfRegisterB, rfEnableWrite, rfRegisterWrite, rfDataIn
  );
  modport slave (
    input  issueValid, issueSrcA, issueSrcB, issueDest, issueWritesDest, opReady,
           wbValid, wbDest, wbData, rfRegA, rfRegB,
    output issueReady, opValid, opA, opB, opDest,
           rfRegisterA, rfRegisterB, rfEnableWrite, rfRegisterWrite, rfDataIn
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand read with writeback bypass and a one-entry output register
module operand_fetch (
  input logic clock,
  input logic reset,
  operand_fetch_if.slave bus
);
  logic [7:0] pending, clr, set, nextA, nextB, opA, opB;
  logic [2:0] opDest;
  logic opValid, hitA, hitB, hitD, hazA, hazB, hazD, space, accept;
  always_comb begin
    hitA = bus.wbValid && bus.wbDest == bus.issueSrcA;
    hitB = bus.wbValid && bus.wbDest == bus.issueSrcB;
    hitD = bus.wbValid && bus.wbDest == bus.issueDest;
    hazA = bus.issueSrcA != 3'd0 && pending[bus.issueSrcA] && !hitA;
    hazB = bus.issueSrcB != 3'd0 && pending[bus.issueSrcB] && !hitB;
    hazD = bus.issueWritesDest && bus.issueDest != 3'd0 && pending[bus.issueDest] && !hitD;
    space = !opValid || bus.opReady;
    bus.issueReady = space && !hazA && !hazB && !hazD;
    accept = bus.issueValid && bus.issueReady;
    // the register file write lands at this same edge, so its read data is still stale
    nextA = bus.issueSrcA == 3'd0 ? 8'd0 : hitA ? bus.wbData : bus.rfRegA;
    nextB = bus.issueSrcB == 3'd0 ? 8'd0 : hitB ? bus.wbData : bus.rfRegB;
    clr = bus.wbValid ? 8'd1 << bus.wbDest : 8'd0;
    set = accept && bus.issueWritesDest && bus.issueDest != 3'd0 ? 8'd1 << bus.issueDest : 8'd0;
    bus.rfRegisterA = bus.issueSrcA;
    bus.rfRegisterB = bus.issueSrcB;
    bus.rfEnableWrite = bus.wbValid;
    bus.rfRegisterWrite = bus.wbDest;
    bus.rfDataIn = bus.wbData;
    bus.opValid = opValid;
    bus.opA = opA;
    bus.opB = opB;
    bus.opDest = opDest;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 8'd0;
      opValid <= 1'b0;
      opA <= 8'd0;
      opB <= 8'd0;
      opDest <= 3'd0;
    end else begin
      pending <= ((pending & ~clr) | set) & 8'hFE;
      opValid <= accept || (opValid && !bus.opReady);
      if (accept) begin
        opA <= nextA;
        opB <= nextB;
        opDest <= bus.issueDest;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a behavioural model
module tb_operand_fetch;
  logic clock = 1'b0;
  logic reset = 1'b1;
  operand_fetch_if bus();
  operand_fetch dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;

  logic [7:0] rf [8];
  assign bus.rfRegA = rf[bus.rfRegisterA];
  assign bus.rfRegB = rf[bus.rfRegisterB];
  always @(posedge clock)
    if (bus.rfEnableWrite && bus.rfRegisterWrite != 3'd0) rf[bus.rfRegisterWrite] <= bus.rfDataIn;

  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit mPend [8];
  logic [7:0] arch [8];
  bit mValid;
  logic [7:0] mA, mB;
  logic [2:0] mDest;

  function automatic bit wbHits(input logic [2:0] r);
    return bus.wbValid && bus.wbDest == r;
  endfunction
  function automatic bit busy(input logic [2:0] r);
    return r != 3'd0 && mPend[r] && !wbHits(r);
  endfunction
  function automatic bit mReady();
    return (!mValid || bus.opReady) && !busy(bus.issueSrcA) && !busy(bus.issueSrcB)
           && !(bus.issueWritesDest && busy(bus.issueDest));
  endfunction
  function automatic logic [7:0] readVal(input logic [2:0] r);
    return r == 3'd0 ? 8'd0 : wbHits(r) ? bus.wbData : arch[r];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      foreach (mPend[i]) mPend[i] = 1'b0;
      mValid = 1'b0;
      mA = 8'd0;
      mB = 8'd0;
      mDest = 3'd0;
    end else begin
      bit acc;
      acc = bus.issueValid && mReady();
      if (acc) begin
        mA = readVal(bus.issueSrcA);
        mB = readVal(bus.issueSrcB);
        mDest = bus.issueDest;
      end
      if (bus.wbValid) begin
        mPend[bus.wbDest] = 1'b0;
        if (bus.wbDest != 3'd0) arch[bus.wbDest] = bus.wbData;
      end
      if (acc && bus.issueWritesDest && bus.issueDest != 3'd0) mPend[bus.issueDest] = 1'b1;
      mValid = acc ? 1'b1 : bus.opReady ? 1'b0 : mValid;
    end
  end

  always @(negedge clock) begin
    chk("issueReady", bus.issueReady, mReady());
    chk("opValid", bus.opValid, mValid);
    if (mValid) begin
      chk("opA", bus.opA, mA);
      chk("opB", bus.opB, mB);
      chk("opDest", bus.opDest, mDest);
    end
    chk("rfRegisterA", bus.rfRegisterA, bus.issueSrcA);
    chk("rfRegisterB", bus.rfRegisterB, bus.issueSrcB);
    chk("rfWrite", {bus.rfEnableWrite, bus.rfRegisterWrite, bus.rfDataIn},
        {bus.wbValid, bus.wbDest, bus.wbData});
  end

  task automatic setIn(input bit iv, input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                       input bit w, input bit ordy, input bit wv, input logic [2:0] wd, input logic [7:0] wdat);
    bus.issueValid = iv;
    bus.issueSrcA = sa;
    bus.issueSrcB = sb;
    bus.issueDest = d;
    bus.issueWritesDest = w;
    bus.opReady = ordy;
    bus.wbValid = wv;
    bus.wbDest = wd;
    bus.wbData = wdat;
    #1;
  endtask
  task automatic step();
    @(posedge clock);
    #2;
  endtask
  task automatic drain();
    for (int r = 1; r < 8; r++) begin
      setIn(0, 0, 0, 0, 0, 1, 1, 3'(r), 8'($urandom));
      step();
    end
    setIn(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'($urandom);
      arch[i] = rf[i];
    end
    rf[0] = 8'hFF;
    setIn(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("readyInReset", bus.issueReady, 1);
    step();
    step();
    reset = 1'b0;
    // reset mid-activity: opValid=1 and registers 2,3 pending
    setIn(1, 1, 1, 2, 1, 1, 0, 0, 0);
    step();
    setIn(1, 1, 1, 3, 1, 1, 0, 0, 0);
    step();
    setIn(1, 2, 0, 6, 0, 1, 0, 0, 0);
    chk("preResetOpValid", bus.opValid, 1);
    chk("preResetStall", bus.issueReady, 0);
    reset = 1'b1;
    #1;
    chk("resetOpValid", bus.opValid, 0);
    chk("resetOpA", bus.opA, 0);
    chk("resetOpB", bus.opB, 0);
    chk("resetReady", bus.issueReady, 1);
    step();
    reset = 1'b0;
    setIn(0, 0, 0, 0, 0, 1, 1, 3, 8'h5A);
    chk("fwdWrite", {bus.rfEnableWrite, bus.rfRegisterWrite, bus.rfDataIn}, {1'b1, 3'd3, 8'h5A});
    chk("postResetReady", bus.issueReady, 1);
    step();
    // zero register reads as 0 and never becomes pending
    setIn(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step();
    chk("zeroOpA", bus.opA, 8'h00);
    chk("zeroOpB", bus.opB, 8'h00);
    setIn(1, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("zeroNotPending", bus.issueReady, 1);
    step();
    // same-cycle bypass
    setIn(0, 0, 0, 0, 0, 1, 1, 2, 8'h11);
    step();
    setIn(1, 2, 0, 1, 0, 1, 1, 2, 8'h77);
    step();
    chk("bypassOpA", bus.opA, 8'h77);
    setIn(1, 2, 2, 1, 0, 1, 0, 0, 0);
    step();
    chk("afterBypassOpA", bus.opA, 8'h77);
    chk("afterBypassOpB", bus.opB, 8'h77);
    // RAW stall cleared by same-cycle writeback
    setIn(1, 0, 0, 4, 1, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      setIn(1, 4, 0, 1, 0, 1, 0, 0, 0);
      chk("rawStall", bus.issueReady, 0);
      step();
    end
    setIn(1, 4, 0, 1, 0, 1, 1, 4, 8'h3C);
    chk("rawRelease", bus.issueReady, 1);
    step();
    chk("rawOpA", bus.opA, 8'h3C);
    setIn(1, 4, 0, 1, 0, 1, 0, 0, 0);
    chk("rawCleared", bus.issueReady, 1);
    step();
    // WAW stall, then set wins over clear
    setIn(1, 0, 0, 5, 1, 1, 0, 0, 0);
    step();
    setIn(1, 0, 0, 5, 1, 1, 0, 0, 0);
    chk("wawStall", bus.issueReady, 0);
    step();
    setIn(1, 0, 0, 5, 1, 1, 1, 5, 8'h42);
    chk("wawRelease", bus.issueReady, 1);
    step();
    setIn(1, 5, 0, 1, 0, 1, 0, 0, 0);
    chk("setWins", bus.issueReady, 0);
    step();
    drain();
    // backpressure holds the entry, then retire and capture at one edge
    setIn(1, 2, 4, 6, 0, 1, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      setIn(1, 1, 1, 7, 0, 0, 0, 0, 0);
      chk("bpReady", bus.issueReady, 0);
      chk("bpDest", bus.opDest, 6);
      step();
    end
    setIn(1, 1, 1, 7, 0, 1, 0, 0, 0);
    step();
    chk("bpRetireValid", bus.opValid, 1);
    chk("bpRetireDest", bus.opDest, 7);
    drain();
    // randomized traffic, with a reset pulse in the middle
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] wd;
      wd = 3'($urandom);
      for (int k = 0; k < 4 && !mPend[wd]; k++) wd = 3'($urandom);
      setIn($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), wd, 8'($urandom));
      if (c == 1500) reset = 1'b1;
      if (c == 1502) reset = 1'b0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue-side client of the 8×8-bit register file. It accepts decoded instructions, reads both source operands through the register file's combinational read ports, and bypasses same-cycle writeback data. A scoreboard stalls any instruction with a RAW or WAW hazard. It also forwards writeback results into the register file's write port and presents operands downstream through a one-entry valid/ready output register.

## Interface
Parameters: none; widths are fixed by the register file at 8 registers × 8 bits.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- issueValid  in  1  instruction offered
- issueReady  out  1  instruction accepted this cycle when high with issueValid (combinational)
- issueSrcA, issueSrcB  in  3  source register indices; index 0 reads as constant 0
- issueDest  in  3  destination register index
- issueWritesDest  in  1  instruction will later write issueDest
- opValid  out  1  operand register holds a valid entry
- opReady  in  1  downstream consumes the entry when high with opValid
- opA, opB  out  8  captured operands
- opDest  out  3  captured destination index
- wbValid  in  1  writeback result present; always accepted, no backpressure
- wbDest  in  3  writeback register index
- wbData  in  8  writeback value
- rfRegisterA, rfRegisterB  out  3  to the register file read selects; equal to issueSrcA and issueSrcB (combinational)
- rfRegA, rfRegB  in  8  register file read data (combinational)
- rfEnableWrite  out  1  equals wbValid
- rfRegisterWrite  out  3  equals wbDest
- rfDataIn  out  8  equals wbData

## Operation
- **Scoreboard.** pending[7:0] marks registers with an outstanding write. Bit 0 is hard-wired to 0.
- **Source hazard.** hazA = (issueSrcA≠0) && pending[issueSrcA] && !(wbValid && wbDest==issueSrcA). hazB is defined the same way for issueSrcB.
- **Destination hazard.** hazD = issueWritesDest && issueDest≠0 && pending[issueDest] && !(wbValid && wbDest==issueDest).
- **Output register free.** space = !opValid || opReady.
- **Issue acceptance.** issueReady = space && !hazA && !hazB && !hazD. issueReady is independent of issueValid.
- **Operand selection at accept (same rule for B).** opA ← 0 if issueSrcA==0; else wbData if wbValid && wbDest==issueSrcA; else rfRegA. The bypass is required because the register file write lands at the same edge, so rfRegA still shows the old value.
- **Destination capture.** opDest ← issueDest at accept.
- **Scoreboard update each edge.**
  - Clear pending[wbDest] when wbValid.
  - Set pending[issueDest] on accept when issueWritesDest && issueDest≠0.
  - If both target the same index, set wins, because the new issue is younger.
  - A writeback to a non-pending register, or to index 0, is harmless. The register file ignores writes to index 0.
- **Output register.**
  - On accept, opValid ← 1.
  - Otherwise, if opReady, opValid ← 0.
  - opA, opB and opDest hold while opValid && !opReady.

## Timing
- **Reset** (asynchronous, immediate):
  - pending = 0.
  - opValid = 0; opA = opB = 0; opDest = 0.
  - issueReady = 1 once reset is released, and combinationally during reset, since nothing is pending.
- **Latency.** Accept at edge N gives opValid=1 with data after edge N.
- **Throughput.** One instruction per cycle with opReady held high.
- **Backpressure.** With opValid=1 and opReady=0, issueReady=0 and the output is stable.
- **Bypass timing.** Writeback and read of the same register in the same cycle return wbData. A writeback in cycle N clears the hazard in cycle N itself, not N+1.
- **Reset during activity.** Reset asserted mid-stall or mid-handshake drops opValid and all pending bits immediately. Downstream must discard the entry.
- **Outputs without a register.** The rf* outputs are purely combinational and have no reset value beyond their inputs.

## Test plan
- **Reset and forwarding.** Assert reset with opValid=1 and pending=8'h0C -> opValid=0, opA=opB=0, issueReady=1 after release. Then wbValid, wbDest=3, wbData=8'h5A -> rfEnableWrite=1, rfRegisterWrite=3, rfDataIn=8'h5A in the same cycle.
- **Zero register.** Issue srcA=0, srcB=0 while the register file returns 8'hFF -> opA=opB=8'h00 next cycle. Issue dest=0 with writes=1 -> pending stays 0.
- **Same-cycle bypass.** Register 2 holds 8'h11. Issue srcA=2 in the same cycle as wbValid, wbDest=2, wbData=8'h77 -> opA=8'h77. A read of register 2 one cycle later returns 8'h77.
- **RAW stall.** Issue dest=4 (writes=1), then srcA=4 -> issueReady=0 for 3 cycles. Then wbValid, wbDest=4, wbData=8'h3C -> accepted in that cycle, opA=8'h3C, pending[4]=0.
- **WAW and set-over-clear.** With pending[5]=1, issue dest=5 stalls. In the cycle with wbDest=5, the new issue with dest=5 is accepted -> pending[5]=1 afterward.
- **Backpressure.** Hold opReady=0 for 4 cycles with opValid=1 -> opA/opB/opDest stable, issueReady=0. Raise opReady with a queued issue -> the old entry retires and the new one is captured at the same edge, opValid stays 1.
